// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
//
// Shared definitions for the multiply-accumulate back end:
//   - mac_state_t : job FSM states (IDLE, ACC, DONE)
//   - MAC_PROD_W  : default product width (matches the 32x32 multiplier output)
//   - MAC_ACC_W   : default accumulator width (8 guard bits over the product)
//   - MAC_LEN_W   : default width of the job-length field
//   - MAC_SAT_ONES: all-ones saturation value at the default accumulator width
//
// Build option: MAC_SAT_EN selects a saturating accumulator
// (see mac_sat_add).
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } mac_state_t;

    localparam int MAC_PROD_W = 64;
    localparam int MAC_ACC_W  = 72;
    localparam int MAC_LEN_W  = 16;

    localparam logic [MAC_ACC_W-1:0] MAC_SAT_ONES = '1;

endpackage

// File: rtl/mac_sat_add.sv
// ---------------------------------------------------------------------------
// mac_sat_add
//
// Combinational W-bit unsigned adder with carry-out and an optional clamp.
//
// Build option: MAC_SAT_EN
//   defined   : a carry out of bit W-1 clamps the sum to all-ones.
//   undefined : the sum wraps modulo 2^W.
// The carry output reports the overflow in both builds.
//
// Ports:
//   a      in  W  running accumulator value
//   b      in  W  zero-extended addend
//   sum    out W  wrapped or clamped result
//   carry  out 1  carry out of bit W-1
// ---------------------------------------------------------------------------
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int W = MAC_ACC_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    // One extra bit holds the carry out of the top of the accumulator.
    logic [W:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[W];
`ifdef MAC_SAT_EN
        // Once clamped, any further addend carries again (or adds zero), so
        // the value holds at all-ones for the rest of the job.
        sum = carry ? {W{1'b1}} : full[W-1:0];
`else
        sum = full[W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//
// Sequential multiply-accumulate back end placed after the combinational
// Wallace multiplier. A job sums `len` unsigned products into an ACC_W-bit
// accumulator and returns one result.
//
// Handshakes (both channels): a beat transfers on a rising edge where valid
// and ready are both high. valid, once raised by the producer, is not
// required to stay high here (the multiplier side may stall freely); the
// result channel holds r_valid, r_data and r_ovf stable until r_ready.
//
// Build option: MAC_SAT_EN selects a saturating accumulator; without it the
// sum wraps. r_ovf is sticky for the job in both builds.
//
// Ports:
//   clk      in   1       clock, rising edge
//   rst_n    in   1       asynchronous active-low reset
//   start    in   1       job request, sampled only in IDLE
//   len      in   LEN_W   number of products, sampled with start
//   clr      in   1       synchronous abort, highest priority
//   busy     out  1       high outside IDLE
//   p_valid  in   1       product valid
//   p_ready  out  1       product accepted this cycle when p_valid
//   p_data   in   PROD_W  unsigned product
//   r_valid  out  1       result valid
//   r_ready  in   1       result taken
//   r_data   out  ACC_W   accumulated sum (meaningful while r_valid)
//   r_ovf    out  1       sticky overflow for the job
//
// ACC_W must be at least PROD_W.
// ---------------------------------------------------------------------------
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = MAC_PROD_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int LEN_W  = MAC_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              clr,
    output logic              busy,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [PROD_W-1:0] p_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [ACC_W-1:0]  r_data,
    output logic              r_ovf
);

    mac_state_t        state;
    mac_state_t        state_next;

    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic              ovf;

    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;
    logic              xfer;
    logic              last;

    // Products are unsigned; a size cast zero-extends and stays legal when
    // ACC_W equals PROD_W.
    assign p_ext = ACC_W'(p_data);

    mac_sat_add #(
        .W (ACC_W)
    ) u_add (
        .a     (acc),
        .b     (p_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // len_q is never zero in ACC, so len_q-1 cannot underflow, and cnt tops
    // out at len_q-1 <= 2^LEN_W-2: the counter never wraps before the match.
    assign last = (cnt == (len_q - LEN_W'(1)));

    // -----------------------------------------------------------------------
    // Next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        p_ready    = 1'b0;
        r_valid    = 1'b0;
        xfer       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                busy    = 1'b1;
                // An aborting cycle must not appear to accept a product.
                p_ready = !clr;
                xfer    = p_valid && !clr;
                if (xfer && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                r_valid = 1'b1;
                if (r_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (clr) begin
            state_next = IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Accumulator, count, latched length and sticky overflow
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero-length job also clears acc so its result reads 0.
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        len_q <= len;
                    end
                end
                ACC: begin
                    if (xfer) begin
                        acc <= add_sum;
                        cnt <= cnt + LEN_W'(1);
                        if (add_carry) begin
                            ovf <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign r_data = acc;
    assign r_ovf  = ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
//
// Two instances share every input: u_wide (ACC_W=72, guard bits) and
// u_narrow (ACC_W=64, so overflow is reachable with two products).
// A job-level model keeps the exact integer sum of accepted products and
// derives the expected result from it; a negedge compare process checks
// both instances every cycle, and directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        clr = 1'b0;
    logic        p_valid = 1'b0;
    logic [63:0] p_data = '0;
    logic        r_ready = 1'b0;

    logic        busy_a, p_ready_a, r_valid_a, r_ovf_a;
    logic [71:0] r_data_a;
    logic        busy_b, p_ready_b, r_valid_b, r_ovf_b;
    logic [63:0] r_data_b;

    mac_accumulator #(.PROD_W(64), .ACC_W(72), .LEN_W(16)) u_wide (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clr(clr),
        .busy(busy_a), .p_valid(p_valid), .p_ready(p_ready_a), .p_data(p_data),
        .r_valid(r_valid_a), .r_ready(r_ready), .r_data(r_data_a), .r_ovf(r_ovf_a)
    );

    mac_accumulator #(.PROD_W(64), .ACC_W(64), .LEN_W(16)) u_narrow (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clr(clr),
        .busy(busy_b), .p_valid(p_valid), .p_ready(p_ready_b), .p_data(p_data),
        .r_valid(r_valid_b), .r_ready(r_ready), .r_data(r_data_b), .r_ovf(r_ovf_b)
    );

    // -----------------------------------------------------------------------
    // Scoreboard counters and check helper
    // -----------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Job-level model: phase 0=idle, 1=collecting, 2=result pending.
    // m_sum is the exact (unbounded) sum of accepted products.
    // -----------------------------------------------------------------------
    int           m_phase = 0;
    int           m_cnt = 0;
    int           m_len = 0;
    logic [127:0] m_sum = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_len   = 0;
            m_sum   = '0;
        end else if (clr) begin
            m_phase = 0;
            m_cnt   = 0;
            m_sum   = '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_sum = '0;
                    m_cnt = 0;
                    if (len == 16'd0) m_phase = 2;
                    else begin
                        m_len   = int'(len);
                        m_phase = 1;
                    end
                end
                1: if (p_valid) begin
                    m_sum = m_sum + {64'd0, p_data};
                    m_cnt++;
                    if (m_cnt == m_len) m_phase = 2;
                end
                default: if (r_ready) m_phase = 0;
            endcase
        end
    end

    function automatic logic [127:0] exp_res(input logic [127:0] s, input int w);
        logic [127:0] lim;
        lim = 128'd1 << w;
        if (s >= lim) begin
`ifdef MAC_SAT_EN
            return lim - 128'd1;
`else
            return s & (lim - 128'd1);
`endif
        end
        return s;
    endfunction

    function automatic logic exp_ovf(input logic [127:0] s, input int w);
        return (s >> w) != 128'd0;
    endfunction

    // Compare process: both instances against the model on every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_a",    busy_a,    m_phase != 0);
            chk("busy_b",    busy_b,    m_phase != 0);
            chk("p_ready_a", p_ready_a, (m_phase == 1) && !clr);
            chk("p_ready_b", p_ready_b, (m_phase == 1) && !clr);
            chk("r_valid_a", r_valid_a, m_phase == 2);
            chk("r_valid_b", r_valid_b, m_phase == 2);
            chk("r_ovf_a",   r_ovf_a,   exp_ovf(m_sum, 72));
            chk("r_ovf_b",   r_ovf_b,   exp_ovf(m_sum, 64));
            if (m_phase == 2) begin
                chk("r_data_a", r_data_a, exp_res(m_sum, 72));
                chk("r_data_b", r_data_b, exp_res(m_sum, 64));
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge)
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input int gap);
        int n;
        repeat (gap) tick();
        p_valid = 1'b1;
        p_data  = d;
        n = 0;
        while (!p_ready_a && n < 20) begin
            tick();
            n++;
        end
        if (!p_ready_a) chk("send_timeout", 1'b0, 1'b1);
        tick();
        p_valid = 1'b0;
    endtask

    task automatic take_result(input int hold);
        int n;
        n = 0;
        while (!r_valid_a && n < 50) begin
            tick();
            n++;
        end
        if (!r_valid_a) chk("result_timeout", 1'b0, 1'b1);
        repeat (hold) tick();
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("idle_after_take", busy_a, 1'b0);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        // Reset values
        #1;
        chk("rst_busy",    busy_a,    1'b0);
        chk("rst_p_ready", p_ready_a, 1'b0);
        chk("rst_r_valid", r_valid_a, 1'b0);
        chk("rst_r_data",  r_data_a,  '0);
        chk("rst_r_ovf",   r_ovf_a,   1'b0);
        chk("rst_r_data_b", r_data_b, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Basic sum: 5 + 7 + (2^64-1) = 2^64 + 11
        do_start(16'd3);
        send(64'd5, 0);
        send(64'd7, 0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("basic_valid", r_valid_a, 1'b1);
        chk("basic_data",  r_data_a,  72'h01_0000_0000_0000_000B);
        chk("basic_ovf",   r_ovf_a,   1'b0);
        chk("basic_ovf_b", r_ovf_b,   1'b1);
`ifdef MAC_SAT_EN
        chk("basic_data_b", r_data_b, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("basic_data_b", r_data_b, 64'd11);
`endif
        take_result(0);

        // Back-to-back job with stalls and result backpressure: 100 + 200
        do_start(16'd2);
        send(64'd100, 3);
        send(64'd200, 3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", r_valid_a, 1'b1);
            chk("stall_data",  r_data_a,  72'd300);
            tick();
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("stall_idle", busy_a, 1'b0);

        // Zero-length job
        do_start(16'd0);
        chk("len0_valid",   r_valid_a, 1'b1);
        chk("len0_data",    r_data_a,  '0);
        chk("len0_p_ready", p_ready_a, 1'b0);
        take_result(2);

        // Overflow at 64 bits: (2^64-1) + 2
        do_start(16'd2);
        send(64'hFFFF_FFFF_FFFF_FFFF, 0);
        send(64'd2, 1);
        chk("ovf_ovf_b", r_ovf_b, 1'b1);
`ifdef MAC_SAT_EN
        chk("ovf_data_b", r_data_b, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("ovf_data_b", r_data_b, 64'd1);
`endif
        chk("ovf_data_a", r_data_a, 72'h01_0000_0000_0000_0001);
        chk("ovf_ovf_a",  r_ovf_a,  1'b0);
        take_result(1);

        // clr mid-job after an overflow: product in the clr cycle is refused
        do_start(16'd3);
        send(64'hFFFF_FFFF_FFFF_FFFF, 0);
        send(64'd2, 0);
        chk("pre_clr_ovf_b", r_ovf_b, 1'b1);
        p_valid = 1'b1;
        p_data  = 64'd9;
        clr     = 1'b1;
        #1;
        chk("clr_p_ready", p_ready_a, 1'b0);
        tick();
        clr     = 1'b0;
        p_valid = 1'b0;
        chk("clr_busy",  busy_a,  1'b0);
        chk("clr_ovf_b", r_ovf_b, 1'b0);
        chk("clr_data",  r_data_a, '0);

        // start pulsed during ACC is ignored: 10 + 20 + 30
        do_start(16'd3);
        send(64'd10, 0);
        start = 1'b1;
        len   = 16'd1;
        tick();
        start = 1'b0;
        send(64'd20, 0);
        chk("ign_not_done", r_valid_a, 1'b0);
        send(64'd30, 0);
        chk("ign_valid", r_valid_a, 1'b1);
        chk("ign_data",  r_data_a,  72'd60);
        take_result(0);

        // Asynchronous reset mid-job
        do_start(16'd4);
        send(64'd1, 0);
        send(64'd2, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",    busy_a,    1'b0);
        chk("arst_p_ready", p_ready_a, 1'b0);
        chk("arst_r_valid", r_valid_a, 1'b0);
        chk("arst_r_data",  r_data_a,  '0);
        chk("arst_r_ovf",   r_ovf_a,   1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("arst_idle",     busy_a,    1'b0);
        chk("arst_no_valid", r_valid_a, 1'b0);

        // A fresh single-product job after reset
        do_start(16'd1);
        send(64'd42, 0);
        chk("post_rst_data", r_data_a, 72'd42);
        take_result(0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
